// File: rtl/program_loader_pkg.sv
// Shared widths, HALT opcode and FSM encoding for the program loader.
package program_loader_pkg;

  localparam int DEF_NB_INSTRUC = 16;
  localparam int DEF_NB_OPCODE  = 5;
  localparam int DEF_NB_ADRR    = 11;
  localparam int DEF_NB_DATA    = 8;

  localparam logic [4:0] HALT_OP = 5'b00000;

  typedef enum logic [2:0] {
    ST_WAIT_HI = 3'd0,
    ST_WAIT_LO = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream in, program-memory write port out.
import program_loader_pkg::*;

interface program_loader_if #(
  parameter int NB_DATA    = DEF_NB_DATA,
  parameter int NB_ADRR    = DEF_NB_ADRR,
  parameter int NB_INSTRUC = DEF_NB_INSTRUC
);
  logic [NB_DATA-1:0]    i_rx_data;
  logic                  i_rx_valid;
  logic                  o_wr_en;
  logic [NB_ADRR-1:0]    o_wr_addr;
  logic [NB_INSTRUC-1:0] o_wr_data;

  modport master (
    output i_rx_data,
    output i_rx_valid,
    input  o_wr_en,
    input  o_wr_addr,
    input  o_wr_data
  );

  modport slave (
    input  i_rx_data,
    input  i_rx_valid,
    output o_wr_en,
    output o_wr_addr,
    output o_wr_data
  );
endinterface

// File: rtl/program_loader.sv
// Assembles byte pairs into instructions and writes them to program
// memory until a HALT opcode; flags overflow if memory fills first.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int NB_INSTRUC = DEF_NB_INSTRUC,
  parameter int NB_OPCODE  = DEF_NB_OPCODE,
  parameter int NB_ADRR    = DEF_NB_ADRR,
  parameter int NB_DATA    = DEF_NB_DATA
) (
  input  logic             i_clk,
  input  logic             i_rst,
  program_loader_if.slave  bus,
  output logic             o_bip_start,
  output logic             o_busy,
  output logic             o_overflow,
  output logic [NB_ADRR:0] o_prog_len
);

  localparam logic [NB_ADRR-1:0] PTR_MAX = '1;

  state_t r_state;
  state_t w_next;

  logic [NB_ADRR-1:0]    r_ptr;
  logic [NB_DATA-1:0]    r_hi;
  logic [NB_ADRR-1:0]    r_wr_addr;
  logic [NB_INSTRUC-1:0] r_wr_data;
  logic [NB_ADRR:0]      r_prog_len;

  logic w_take_hi;
  logic w_take_lo;
  logic w_ptr_inc;
  logic w_halt;
  logic w_full;

  assign w_halt = r_wr_data[NB_INSTRUC-1 -: NB_OPCODE]
                  == NB_OPCODE'(HALT_OP);
  assign w_full = (r_ptr == PTR_MAX);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_WAIT_HI;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_take_hi = 1'b0;
    w_take_lo = 1'b0;
    w_ptr_inc = 1'b0;
    unique case (r_state)
      ST_WAIT_HI: begin
        if (bus.i_rx_valid) begin
          w_take_hi = 1'b1;
          w_next    = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (bus.i_rx_valid) begin
          w_take_lo = 1'b1;
          w_next    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // HALT wins even at the last address; a byte seen on exit is dropped
        if (w_halt) begin
          w_next = ST_DONE;
        end else if (w_full) begin
          w_next = ST_ERROR;
        end else begin
          w_ptr_inc = 1'b1;
          if (bus.i_rx_valid) begin
            w_take_hi = 1'b1;
            w_next    = ST_WAIT_LO;
          end else begin
            w_next    = ST_WAIT_HI;
          end
        end
      end
      ST_DONE:  w_next = ST_DONE;
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_WAIT_HI;
    endcase
  end

  // Write address/data are captured with the low byte so they hold afterwards
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ptr      <= '0;
      r_hi       <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_prog_len <= '0;
    end else begin
      if (w_take_hi) r_hi <= bus.i_rx_data;
      if (w_take_lo) begin
        r_wr_data <= {r_hi, bus.i_rx_data};
        r_wr_addr <= r_ptr;
      end
      if (w_ptr_inc) r_ptr <= r_ptr + 1'b1;
      if (r_state == ST_WRITE) r_prog_len <= r_prog_len + 1'b1;
    end
  end

  assign bus.o_wr_en   = (r_state == ST_WRITE);
  assign bus.o_wr_addr = r_wr_addr;
  assign bus.o_wr_data = r_wr_data;
  assign o_bip_start   = (r_state == ST_DONE);
  assign o_overflow    = (r_state == ST_ERROR);
  assign o_prog_len    = r_prog_len;
  assign o_busy        = (r_state == ST_WAIT_LO)
                      || (r_state == ST_WRITE)
                      || ((r_state == ST_WAIT_HI) && (r_ptr != '0));

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: vector table, hand sequences and a random stream
// compared against an instruction-level reference model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bip;
  logic        busy;
  logic        ovf;
  logic [11:0] plen;

  program_loader_if bus ();

  program_loader dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .bus         (bus),
    .o_bip_start (bip),
    .o_busy      (busy),
    .o_overflow  (ovf),
    .o_prog_len  (plen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] sent_q[$];

  always @(negedge clk)
    if (rst_n && bus.o_wr_en)
      wq.push_back('{bus.o_wr_addr, bus.o_wr_data});

  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
    rst_n = 1'b0;
    wq.delete();
    sent_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.i_rx_valid = 1'b0;
    idle(gap);
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    sent_q.push_back(w);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  // Instruction-level model: write in order from address 0, stop after
  // the first HALT, or after 2048 non-HALT writes with overflow.
  task automatic check_model(input string tag);
    wr_t exp_q[$];
    bit  done = 0;
    bit  err = 0;
    int  bad = 0;
    foreach (sent_q[i]) begin
      if (done || err) break;
      exp_q.push_back('{11'(exp_q.size()), sent_q[i]});
      if (sent_q[i][15:11] == 5'd0) done = 1;
      else if (exp_q.size() == 2048) err = 1;
    end
    chk({tag, " count"}, wq.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < wq.size(); j++)
      if (wq[j].a !== exp_q[j].a || wq[j].d !== exp_q[j].d) bad++;
    chk({tag, " entries"}, bad, 0);
    chk({tag, " prog_len"}, plen, exp_q.size());
    chk({tag, " bip"}, bip, done);
    chk({tag, " ovf"}, ovf, err);
    chk({tag, " busy"}, busy, !done && !err && exp_q.size() > 0);
    chk({tag, " wr_en"}, bus.o_wr_en, 0);
    if (exp_q.size() > 0)
      chk({tag, " hold"}, bus.o_wr_data, exp_q[$].d);
  endtask

  typedef struct packed {
    logic [2:0]  n;
    logic [63:0] words;
    logic [1:0]  gap;
    logic [2:0]  exp_wr;
    logic        exp_bip;
    logic [11:0] exp_len;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [15:0] w;
    logic [4:0]  op;
    logic [11:0] len_snap;
    logic [63:0] ws;
    vec_t        v;

    tbl[0] = '{3'd2, 64'h0805_0000_0000_0000, 2'd0, 3'd2, 1'b1, 12'd2, 1'b0};
    tbl[1] = '{3'd4, 64'h0801_1002_1803_0000, 2'd0, 3'd4, 1'b1, 12'd4, 1'b0};
    tbl[2] = '{3'd4, 64'h0801_1002_1803_0000, 2'd1, 3'd4, 1'b1, 12'd4, 1'b0};
    tbl[3] = '{3'd3, 64'h0811_0822_0833_0000, 2'd2, 3'd3, 1'b0, 12'd3, 1'b1};
    tbl[4] = '{3'd3, 64'h07FF_0900_0A00_0000, 2'd0, 3'd1, 1'b1, 12'd1, 1'b0};
    tbl[5] = '{3'd2, 64'hF800_0000_0000_0000, 2'd3, 3'd2, 1'b1, 12'd2, 1'b0};

    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
    #2;
    chk("reset bip", bip, 0);
    chk("reset busy", busy, 0);
    chk("reset len", plen, 0);
    chk("reset wr_en", bus.o_wr_en, 0);

    for (int t = 0; t < 6; t++) begin
      v = tbl[t];
      ws = v.words;
      do_reset();
      for (int i = 0; i < v.n; i++) begin
        w = ws[63-16*i -: 16];
        send_byte(w[15:8], int'(v.gap));
        send_byte(w[7:0], int'(v.gap));
      end
      idle(4);
      chk($sformatf("vec%0d count", t), wq.size(), v.exp_wr);
      for (int j = 0; j < v.exp_wr && j < wq.size(); j++) begin
        chk($sformatf("vec%0d addr%0d", t, j), wq[j].a, j);
        chk($sformatf("vec%0d data%0d", t, j), wq[j].d, ws[63-16*j -: 16]);
      end
      chk($sformatf("vec%0d len", t), plen, v.exp_len);
      chk($sformatf("vec%0d bip", t), bip, v.exp_bip);
      chk($sformatf("vec%0d busy", t), busy, v.exp_busy);
      chk($sformatf("vec%0d ovf", t), ovf, 0);
      chk($sformatf("vec%0d hold", t), bus.o_wr_data,
          ws[63-16*(int'(v.exp_wr)-1) -: 16]);
    end

    // Busy profile, one-cycle write latency and output hold
    do_reset();
    chk("busy idle", busy, 0);
    send_byte(8'h08, 0);
    chk("busy wait_lo", busy, 1);
    send_byte(8'h01, 0);
    chk("lat wr_en", bus.o_wr_en, 1);
    chk("lat addr", bus.o_wr_addr, 0);
    chk("lat data", bus.o_wr_data, 16'h0801);
    idle(1);
    chk("after wr_en", bus.o_wr_en, 0);
    chk("busy ptr>0", busy, 1);
    chk("hold data", bus.o_wr_data, 16'h0801);

    // Bytes after DONE are ignored
    do_reset();
    send_word(16'h0805, 0);
    send_word(16'h0000, 0);
    idle(3);
    len_snap = plen;
    send_byte(8'h09, 0);
    send_byte(8'h01, 0);
    send_byte(8'h0A, 1);
    send_byte(8'h02, 1);
    idle(3);
    chk("post-done count", wq.size(), 2);
    chk("post-done len", plen, len_snap);
    chk("post-done bip", bip, 1);

    // Asynchronous reset mid-load, stale high byte discarded
    do_reset();
    send_word(16'h1234, 0);
    idle(2);
    send_byte(8'h55, 0);
    chk("mid busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async busy", busy, 0);
    chk("async len", plen, 0);
    chk("async data", bus.o_wr_data, 0);
    chk("async addr", bus.o_wr_addr, 0);
    chk("async wr_en", bus.o_wr_en, 0);
    chk("async bip", bip, 0);
    wq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    idle(3);
    chk("reload count", wq.size(), 2);
    if (wq.size() >= 2) begin
      chk("reload a0", wq[0].a, 0);
      chk("reload d0", wq[0].d, 16'h1001);
      chk("reload a1", wq[1].a, 1);
      chk("reload d1", wq[1].d, 16'h0000);
    end
    chk("reload bip", bip, 1);

    // Random streams with random spacing
    for (int r = 0; r < 40; r++) begin
      do_reset();
      for (int k = 0; k < int'($urandom_range(1, 10)); k++) begin
        op = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        w  = {op, 11'($urandom)};
        sent_q.push_back(w);
        send_byte(w[15:8], int'($urandom_range(0, 2)));
        send_byte(w[7:0], int'($urandom_range(0, 2)));
      end
      idle(3);
      check_model($sformatf("rnd%0d", r));
    end

    // Memory full without HALT, then one extra instruction
    do_reset();
    for (int i = 0; i < 2048; i++)
      send_word({5'b00001, 11'(i)}, 0);
    send_word(16'h0800, 0);
    idle(3);
    check_model("overflow");
    if (wq.size() > 0)
      chk("overflow last addr", wq[$].a, 11'h7FF);

    // HALT as the 2048th instruction
    do_reset();
    for (int i = 0; i < 2047; i++)
      send_word({5'b00010, 11'(i)}, 0);
    send_word(16'h0000, 0);
    idle(3);
    check_model("halt2048");
    chk("halt2048 len", plen, 2048);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
